// File: rtl/fb_axi_writer.sv
// Frame-buffer write master for one PS7 S_AXI_HP port (AXI3, 64-bit): buffers whole bursts and writes frames linearly from BASE.
// Optional feature macro FB_WRITER_ERR_EN: latch a non-OKAY BRESP on err_o until reset.
module fb_axi_writer #(
  parameter logic [31:0] BASE            = 32'h2000_0000,
  parameter int          FRAME_WORDS     = 259200,
  parameter int          BURST_LEN       = 16,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wen_i,
  input  logic        sof_i,
  input  logic        in_valid_i,
  input  logic [63:0] in_data_i,
  output logic        ovf_o,
  output logic        err_o,
  output logic        m_axi_aclk,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic [3:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [3:0]  m_axi_awcache,
  output logic [5:0]  m_axi_awid,
  output logic [5:0]  m_axi_wid,
  output logic [1:0]  m_axi_awlock,
  output logic [2:0]  m_axi_awprot,
  output logic [3:0]  m_axi_awqos,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp
);
  localparam int DEPTH = 2 * BURST_LEN;
  localparam int PW    = $clog2(DEPTH);
  localparam int SW    = PW + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [63:0]   r_mem [DEPTH];
  logic [63:0]   r_head;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_committed;
  logic [BW-1:0] r_beat;
  logic [OW-1:0] r_outstanding;
  logic [28:0]   r_word_idx;
  logic [31:0]   r_awaddr;
  logic          r_ovf;

  logic          w_in_acc;
  logic          w_sof;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_aw_hs;
  logic          w_last_beat;
  logic          w_issue;
  logic [CW-1:0] w_committable;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_committed_next;
  logic [SW-1:0] w_sof_sum;
  logic [PW-1:0] w_sof_wp;
  logic [PW-1:0] w_wr_base;
  logic [PW-1:0] w_rd_ptr_next;
  logic [28:0]   w_idx_inc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_in_acc      = in_valid_i & wen_i;
  assign w_sof         = w_in_acc & sof_i;
  assign w_full        = (r_count == CW'(DEPTH));
  // Committed words never exceed one burst, so the sof word always has room.
  assign w_push        = w_in_acc & (w_sof | ~w_full);
  assign w_drop        = w_in_acc & ~w_sof & w_full;
  assign w_pop         = m_axi_wvalid & m_axi_wready;
  assign w_aw_hs       = m_axi_awvalid & m_axi_awready;
  assign w_last_beat   = (r_beat == BW'(BURST_LEN - 1));
  assign w_committable = r_count - r_committed;
  // A burst is never launched in a sof cycle: those uncommitted words are being thrown away.
  assign w_issue       = (r_state == S_IDLE) & ~w_sof
                       & (w_committable >= CW'(BURST_LEN))
                       & (r_outstanding < OW'(MAX_OUTSTANDING));

  // On sof the write pointer snaps back to just past the committed words.
  assign w_sof_sum     = {1'b0, r_rd_ptr} + SW'(r_committed);
  assign w_sof_wp      = (w_sof_sum >= SW'(DEPTH)) ? PW'(w_sof_sum - SW'(DEPTH)) : PW'(w_sof_sum);
  assign w_wr_base     = w_sof ? w_sof_wp : r_wr_ptr;
  assign w_rd_ptr_next = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
  assign w_idx_inc     = r_word_idx + 29'(BURST_LEN);

  always_comb begin
    if (w_sof) begin
      w_count_next = r_committed - CW'(w_pop) + CW'(1);
    end else begin
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    end
    w_committed_next = r_committed + (w_issue ? CW'(BURST_LEN) : '0) - CW'(w_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_next = S_AW;
      S_AW:    if (m_axi_awready) w_state_next = S_W;
      S_W:     if (m_axi_wready && w_last_beat) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    case (r_state)
      S_AW: m_axi_awvalid = 1'b1;
      S_W: begin
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = w_last_beat;
      end
      default: ;
    endcase
  end

  // Registered read of the next head keeps wdata stable through wready stalls.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[w_wr_base] <= in_data_i;
    r_head <= r_mem[w_rd_ptr_next];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_committed   <= '0;
      r_beat        <= '0;
      r_outstanding <= '0;
      r_word_idx    <= '0;
      r_awaddr      <= BASE;
      r_ovf         <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_committed <= w_committed_next;
      r_rd_ptr    <= w_rd_ptr_next;
      if (w_push) r_wr_ptr <= ptr_inc(w_wr_base);
      if (w_drop) r_ovf <= 1'b1;
      if (w_pop) r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
      if (w_aw_hs && !(m_axi_bvalid && r_outstanding != '0)) begin
        r_outstanding <= r_outstanding + OW'(1);
      end else if (!w_aw_hs && m_axi_bvalid && r_outstanding != '0) begin
        r_outstanding <= r_outstanding - OW'(1);
      end
      if (w_sof) begin
        r_word_idx <= '0;
      end else if (w_issue) begin
        r_awaddr   <= BASE + {r_word_idx, 3'b000};
        r_word_idx <= (w_idx_inc == 29'(FRAME_WORDS)) ? '0 : w_idx_inc;
      end
    end
  end

`ifdef FB_WRITER_ERR_EN
  logic r_err;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (m_axi_bvalid && m_axi_bresp != 2'b00) begin
      r_err <= 1'b1;
    end
  end
  assign err_o = r_err;
`else
  logic w_unused;
  assign w_unused = ^m_axi_bresp;
  assign err_o    = 1'b0;
`endif

  assign ovf_o         = r_ovf;
  assign m_axi_aclk    = clk_i;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = 4'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'b011;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awid    = 6'd0;
  assign m_axi_wid     = 6'd0;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wdata   = r_head;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_bready  = 1'b1;

endmodule
